// File: rtl/codel_drop_decider_pkg.sv
// Shared types for the CoDel drop engine: time/count widths, FSM states and
// the modular time comparison used by both the design and its bench model.
package codel_drop_decider_pkg;

  localparam int TIME_W  = 32;
  localparam int COUNT_W = 16;

  typedef logic [TIME_W-1:0]  time_ctr_t;
  typedef logic [COUNT_W-1:0] count_t;

  typedef enum logic {
    NOT_DROPPING = 1'b0,
    DROPPING     = 1'b1
  } state_t;

  // a is at or after b on the wrapping time line
  function automatic logic time_ge(input time_ctr_t a, input time_ctr_t b);
    time_ctr_t diff;
    diff = a - b;
    return ~diff[TIME_W-1];
  endfunction

endpackage

// File: rtl/codel_drop_decider_control_law.sv
// CoDel control law: next = base + interval / isqrt(count), fully combinational.
module compute_control_law
  import codel_drop_decider_pkg::*;
(
  input  logic [31:0] base,
  input  logic [15:0] count,
  input  logic [31:0] interval,
  output logic [31:0] next
);

  logic [7:0]  root_s;
  logic [7:0]  trial_s;
  logic [15:0] square_s;
  logic [7:0]  divisor_s;

  // bit-serial integer square root, unrolled over the 8 result bits
  always_comb begin
    root_s   = 8'd0;
    trial_s  = 8'd0;
    square_s = 16'd0;
    for (int i = 7; i >= 0; i--) begin
      trial_s  = root_s | (8'd1 << i);
      square_s = {8'd0, trial_s} * {8'd0, trial_s};
      if (square_s <= count) begin
        root_s = trial_s;
      end else begin
        root_s = root_s;
      end
    end
  end

  // count is never 0 on the paths that use the result; guard the divider anyway
  assign divisor_s = (root_s == 8'd0) ? 8'd1 : root_s;
  assign next      = base + (interval / {24'd0, divisor_s});

endmodule

// File: rtl/codel_drop_decider.sv
// Dequeue-side CoDel drop engine with registered drop/forward decision.
// Optional CODEL_DROP_STATS_EN adds a saturating o__drop_total counter.
module codel_drop_decider
  import codel_drop_decider_pkg::*;
#(
  parameter int unsigned MTU_BYTES        = 1500,
  parameter int unsigned RESEED_INTERVALS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i__deq_valid,
  input  logic [31:0] i__sojourn,
  input  logic [31:0] i__now,
  input  logic [31:0] i__backlog_bytes,
  input  logic [31:0] i__target,
  input  logic [31:0] i__interval,
  output logic        o__dec_valid,
  output logic        o__drop,
  output logic        o__dropping,
  output logic [15:0] o__count,
  output logic [31:0] o__drop_next
`ifdef CODEL_DROP_STATS_EN
  ,
  output logic [31:0] o__drop_total
`endif
);

  localparam time_ctr_t   MTU_TH      = 32'(MTU_BYTES);
  localparam logic [47:0] RESEED_MULT = 48'(RESEED_INTERVALS);

  state_t    state_r, state_s;
  time_ctr_t first_above_r, first_above_s;
  time_ctr_t drop_next_r, drop_next_s;
  count_t    count_r, count_s, last_count_r, last_count_s;
  logic      dec_valid_r, drop_r, drop_s;

  count_t    count_inc_s, delta_s, entry_count_s, cl_count_s;
  time_ctr_t fa_sum_s, since_next_s, cl_base_s, cl_next_s;
  logic      below_s, ok_s, recent_s;

  assign count_inc_s   = (count_r == 16'hFFFF) ? count_r : count_r + 16'd1;
  assign delta_s       = count_r - last_count_r;
  assign since_next_s  = i__now - drop_next_r;
  // negative distance means drop_next is still ahead, which is always recent
  assign recent_s      = since_next_s[31] ||
                         ({16'd0, since_next_s} < ({16'd0, i__interval} * RESEED_MULT));
  assign entry_count_s = ((delta_s > 16'd1) && recent_s) ? delta_s : 16'd1;
  assign cl_base_s     = (state_r == DROPPING) ? drop_next_r : i__now;
  assign cl_count_s    = (state_r == DROPPING) ? count_inc_s : entry_count_s;
  assign fa_sum_s      = i__now + i__interval;
  assign below_s       = (i__sojourn < i__target) || (i__backlog_bytes < MTU_TH);

  compute_control_law u_control_law (
    .base     (cl_base_s),
    .count    (cl_count_s),
    .interval (i__interval),
    .next     (cl_next_s)
  );

  // first-above tracking and ok_to_drop qualification
  always_comb begin
    first_above_s = first_above_r;
    ok_s          = 1'b0;
    if (!i__deq_valid) begin
      first_above_s = first_above_r;
    end else if (below_s) begin
      first_above_s = 32'd0;
    end else if (first_above_r == 32'd0) begin
      first_above_s = (fa_sum_s == 32'd0) ? 32'd1 : fa_sum_s;
    end else begin
      ok_s = time_ge(i__now, first_above_r);
    end
  end

  // dropping FSM next state and drop decision
  always_comb begin
    state_s      = state_r;
    count_s      = count_r;
    last_count_s = last_count_r;
    drop_next_s  = drop_next_r;
    drop_s       = 1'b0;
    if (i__deq_valid) begin
      case (state_r)
        DROPPING: begin
          if (!ok_s) begin
            state_s = NOT_DROPPING;
          end else if (time_ge(i__now, drop_next_r)) begin
            drop_s      = 1'b1;
            count_s     = count_inc_s;
            drop_next_s = cl_next_s;
          end else begin
            drop_s = 1'b0;
          end
        end
        NOT_DROPPING: begin
          if (ok_s) begin
            drop_s       = 1'b1;
            state_s      = DROPPING;
            count_s      = entry_count_s;
            last_count_s = entry_count_s;
            drop_next_s  = cl_next_s;
          end else begin
            drop_s = 1'b0;
          end
        end
        default: state_s = NOT_DROPPING;
      endcase
    end else begin
      drop_s = 1'b0;
    end
  end

  // state and decision registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= NOT_DROPPING;
      first_above_r <= 32'd0;
      drop_next_r   <= 32'd0;
      count_r       <= 16'd0;
      last_count_r  <= 16'd0;
      dec_valid_r   <= 1'b0;
      drop_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      first_above_r <= first_above_s;
      drop_next_r   <= drop_next_s;
      count_r       <= count_s;
      last_count_r  <= last_count_s;
      dec_valid_r   <= i__deq_valid;
      drop_r        <= drop_s;
    end
  end

  assign o__dec_valid = dec_valid_r;
  assign o__drop      = drop_r;
  assign o__dropping  = (state_r == DROPPING);
  assign o__count     = count_r;
  assign o__drop_next = drop_next_r;

`ifdef CODEL_DROP_STATS_EN
  logic [31:0] drop_total_r;

  // saturating drop counter, updated alongside the drop strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_total_r <= 32'd0;
    end else if (drop_s && (drop_total_r != 32'hFFFF_FFFF)) begin
      drop_total_r <= drop_total_r + 32'd1;
    end else begin
      drop_total_r <= drop_total_r;
    end
  end

  assign o__drop_total = drop_total_r;
`endif

endmodule

// File: tb/tb_codel_drop_decider.sv
// Self-checking bench for codel_drop_decider: directed scenarios plus randomized
// traffic against a behavioural CoDel model.
module tb_codel_drop_decider;
  import codel_drop_decider_pkg::*;

  localparam int MTU = 1500;
  localparam int RESEED = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        deq_valid = 1'b0;
  logic [31:0] sojourn = 32'd0, now_in = 32'd0, backlog = 32'd0;
  logic [31:0] target_v = 32'd5, interval_v = 32'd100;
  logic        dec_valid, drop, dropping;
  logic [15:0] count;
  logic [31:0] drop_next;
  logic [31:0] drop_total;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit          m_dropping;
  logic [31:0] m_fa, m_dn;
  int          m_count, m_last;
  longint      m_total;
  bit          exp_valid, exp_drop;

  always #5 clk = ~clk;

  codel_drop_decider #(.MTU_BYTES(MTU), .RESEED_INTERVALS(RESEED)) dut (
    .clk(clk), .rst_n(rst_n), .i__deq_valid(deq_valid), .i__sojourn(sojourn),
    .i__now(now_in), .i__backlog_bytes(backlog), .i__target(target_v),
    .i__interval(interval_v), .o__dec_valid(dec_valid), .o__drop(drop),
    .o__dropping(dropping), .o__count(count), .o__drop_next(drop_next)
`ifdef CODEL_DROP_STATS_EN
    , .o__drop_total(drop_total)
`endif
  );

`ifndef CODEL_DROP_STATS_EN
  assign drop_total = 32'(m_total);
`endif

  function automatic logic [31:0] cl(input logic [31:0] base, input int cnt, input logic [31:0] iv);
    int r = 1;
    while ((r + 1) * (r + 1) <= cnt) r++;
    return base + iv / 32'(r);
  endfunction

  task automatic model_reset();
    m_dropping = 0; m_fa = 0; m_dn = 0; m_count = 0; m_last = 0; m_total = 0;
    exp_valid = 0; exp_drop = 0;
  endtask

  task automatic model_step(input logic [31:0] now, input logic [31:0] soj, input logic [31:0] bl);
    bit ok = 0;
    int delta;
    logic [31:0] d;
    longint sd;
    exp_valid = 1; exp_drop = 0;
    if (soj < target_v || bl < 32'(MTU)) m_fa = 0;
    else if (m_fa == 0) begin
      m_fa = now + interval_v;
      if (m_fa == 0) m_fa = 1;
    end else ok = time_ge(now, m_fa);
    if (m_dropping) begin
      if (!ok) m_dropping = 0;
      else if (time_ge(now, m_dn)) begin
        exp_drop = 1;
        if (m_count < 65535) m_count++;
        m_dn = cl(m_dn, m_count, interval_v);
      end
    end else if (ok) begin
      delta = (m_count - m_last) & 32'hFFFF;
      d = now - m_dn;
      sd = longint'($signed(d));
      exp_drop = 1; m_dropping = 1;
      m_count = (delta > 1 && sd < longint'(interval_v) * RESEED) ? delta : 1;
      m_dn = cl(now, m_count, interval_v);
      m_last = m_count;
    end
    if (exp_drop && m_total < 64'hFFFF_FFFF) m_total++;
  endtask

  task automatic step(input bit v, input logic [31:0] now, input logic [31:0] soj, input logic [31:0] bl);
    @(negedge clk);
    deq_valid = v; now_in = now; sojourn = soj; backlog = bl;
    if (v) model_step(now, soj, bl);
    else begin exp_valid = 0; exp_drop = 0; end
    @(posedge clk); #1;
    deq_valid = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_dec_valid: got %0b want 0", dec_valid); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %0b want 0", drop); end
    checks++; if (dropping !== 1'b0) begin errors++; $display("FAIL reset_dropping: got %0b want 0", dropping); end
    checks++; if (count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
    checks++; if (drop_next !== 32'd0) begin errors++; $display("FAIL reset_drop_next: got %0d want 0", drop_next); end
  endtask

  task automatic test_below_target();
    target_v = 32'd5; interval_v = 32'd100;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'(i * 50), 32'd3, 32'd4000);
      checks++; if (dec_valid !== 1'b1 || drop !== 1'b0 || dropping !== 1'b0) begin
        errors++; $display("FAIL below_target[%0d]: got v=%0b d=%0b dr=%0b want 1/0/0", i, dec_valid, drop, dropping);
      end
    end
  endtask

  task automatic test_first_drop();
    for (int t = 1000; t <= 1100; t += 10) begin
      step(1'b1, 32'(t), 32'd10, 32'd4000);
      checks++; if (drop !== exp_drop || drop !== (t == 1100)) begin
        errors++; $display("FAIL first_drop@%0d: got %0b want %0b", t, drop, t == 1100);
      end
    end
    checks++; if (count !== 16'd1 || drop_next !== 32'd1200 || dropping !== 1'b1) begin
      errors++; $display("FAIL first_drop_state: got c=%0d dn=%0d dr=%0b want 1/1200/1", count, drop_next, dropping);
    end
    step(1'b1, 32'd1150, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b0 || dropping !== 1'b1) begin
      errors++; $display("FAIL early_forward: got d=%0b dr=%0b want 0/1", drop, dropping);
    end
    step(1'b1, 32'd1200, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b1 || count !== 16'd2 || drop_next !== 32'd1300) begin
      errors++; $display("FAIL second_drop: got d=%0b c=%0d dn=%0d want 1/2/1300", drop, count, drop_next);
    end
  endtask

  task automatic test_exit_reseed();
    step(1'b1, 32'd1300, 32'd10, 32'd4000);
    step(1'b1, 32'd1400, 32'd10, 32'd4000);
    step(1'b1, 32'd1450, 32'd10, 32'd4000);
    checks++; if (count !== 16'd5 || drop_next !== 32'd1500) begin
      errors++; $display("FAIL count5: got c=%0d dn=%0d want 5/1500", count, drop_next);
    end
    step(1'b1, 32'd1460, 32'd2, 32'd4000);
    checks++; if (drop !== 1'b0 || dropping !== 1'b0) begin
      errors++; $display("FAIL exit: got d=%0b dr=%0b want 0/0", drop, dropping);
    end
    step(1'b1, 32'd1470, 32'd10, 32'd4000);
    step(1'b1, 32'd1570, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b1 || count !== 16'd4 || drop_next !== 32'd1620) begin
      errors++; $display("FAIL reseed: got d=%0b c=%0d dn=%0d want 1/4/1620", drop, count, drop_next);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    interval_v = 32'd100;
    step(1'b1, 32'hFFFF_FFF0, 32'd10, 32'd4000);
    step(1'b1, 32'h0000_0022, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL wrap_early: got %0b want 0", drop); end
    step(1'b1, 32'h0000_0054, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b1 || count !== 16'd1 || drop_next !== 32'h0000_00B8) begin
      errors++; $display("FAIL wrap_drop: got d=%0b c=%0d dn=%0h want 1/1/b8", drop, count, drop_next);
    end
    apply_reset();
    step(1'b1, 32'hFFFF_FF9C, 32'd10, 32'd4000);
    step(1'b1, 32'd0, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL zero_sum_early: got %0b want 0", drop); end
    step(1'b1, 32'd1, 32'd10, 32'd4000);
    checks++; if (drop !== 1'b1 || drop_next !== 32'd101) begin
      errors++; $display("FAIL zero_sum_drop: got d=%0b dn=%0d want 1/101", drop, drop_next);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    bit v;
    apply_reset();
    interval_v = 32'd100;
    t = $urandom();
    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 0) interval_v = 32'($urandom_range(20, 200));
      v = ($urandom_range(0, 4) != 0);
      t = t + 32'($urandom_range(0, 25));
      step(v, t, 32'($urandom_range(0, 12)), ($urandom_range(0, 3) == 0) ? 32'd1000 : 32'd4000);
      checks++;
      if (dec_valid !== exp_valid || (exp_valid && drop !== exp_drop) || dropping !== m_dropping ||
          count !== 16'(m_count) || drop_next !== m_dn || drop_total !== 32'(m_total)) begin
        errors++;
        $display("FAIL random[%0d]: got v=%0b d=%0b dr=%0b c=%0d dn=%0h tot=%0d want %0b/%0b/%0b/%0d/%0h/%0d",
                 i, dec_valid, drop, dropping, count, drop_next, drop_total,
                 exp_valid, exp_drop, m_dropping, m_count, m_dn, m_total);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    interval_v = 32'd100;
    step(1'b1, 32'd5000, 32'd10, 32'd4000);
    step(1'b1, 32'd5100, 32'd10, 32'd4000);
    for (int k = 0; k < 20 && m_count < 7; k++) step(1'b1, m_dn, 32'd10, 32'd4000);
    checks++; if (count !== 16'd7 || dropping !== 1'b1 || drop !== 1'b1) begin
      errors++; $display("FAIL pre_reset: got c=%0d dr=%0b d=%0b want 7/1/1", count, dropping, drop);
    end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++; if (count !== 16'd0 || dropping !== 1'b0 || drop !== 1'b0 || dec_valid !== 1'b0 || drop_next !== 32'd0) begin
      errors++; $display("FAIL async_reset: got c=%0d dr=%0b d=%0b v=%0b dn=%0d want all 0", count, dropping, drop, dec_valid, drop_next);
    end
`ifdef CODEL_DROP_STATS_EN
    checks++; if (drop_total !== 32'd0) begin errors++; $display("FAIL async_reset_total: got %0d want 0", drop_total); end
`endif
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_below_target();
    test_first_drop();
    test_exit_reseed();
    test_wrap();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/codel_drop_decider.md
# codel_drop_decider

Dequeue-side CoDel drop engine. Evaluates each dequeued packet's sojourn time against the configured target and interval, keeps the CoDel dropping state (first-above time, drop count, next drop time), and issues a registered drop/forward decision. It sits between the packet buffer's dequeue port and the egress scheduler. It is the consumer of the control-law computation: it supplies the base time and count and stores the returned next-drop time.

## Interface
- MTU_BYTES, 1500, queue-backlog threshold below which the queue is never considered persistently above target
- RESEED_INTERVALS, 16, window, in intervals, for restarting count from the previous drop episode
- clk  in  1  sole clock; everything rising-edge
- rst_n  in  1  asynchronous assert, active-low reset
- i__deq_valid  in  1  a packet is dequeued this cycle; its other i__ fields are valid
- i__sojourn  in  TimeCtr  packet sojourn time (now − enqueue stamp)
- i__now  in  TimeCtr  free-running time counter, modular
- i__backlog_bytes  in  32  queue bytes remaining after this dequeue
- i__target  in  TimeCtr  sojourn target (quasi-static)
- i__interval  in  TimeCtr  CoDel interval (quasi-static)
- o__dec_valid  out  1  decision strobe, one cycle after i__deq_valid
- o__drop  out  1  qualified by o__dec_valid: 1 = drop, 0 = forward
- o__dropping  out  1  FSM in DROPPING
- o__count  out  Count  current drop count
- o__drop_next  out  TimeCtr  scheduled next drop time

## Operation
- FSM states: NOT_DROPPING, DROPPING. Registers: first_above (0 = unset), count, last_count, drop_next.
- Per accepted dequeue (i__deq_valid=1), compute ok_to_drop:
  - sojourn < target, or backlog < MTU_BYTES → first_above := 0, ok=0.
  - else if first_above==0 → first_above := now+interval (if the sum is 0, store 1), ok=0.
  - else ok = (now − first_above, signed) ≥ 0.
- DROPPING: ok=0 → NOT_DROPPING, forward. ok=1 and (now − drop_next, signed) ≥ 0 → drop, count := sat(count+1), drop_next := CL(drop_next, count+1). Otherwise forward.
- NOT_DROPPING: ok=1 → drop, enter DROPPING; delta = count − last_count; count := (delta>1 and (now − drop_next, signed) < RESEED_INTERVALS·interval) ? delta : 1; drop_next := CL(now, new count); last_count := new count. ok=0 → forward.
- At most one drop per dequeue; no catch-up loop.
- All time compares use modular signed difference (TimeCtr-wide two's complement); wrap of i__now is transparent.
- count saturates at all-ones; it never wraps to 0.
- Cycles without i__deq_valid: no state change, o__dec_valid=0.

## Timing
- Latency 1: decision and updated state are registered on the edge after i__deq_valid.
- Full throughput: a dequeue is accepted every cycle with no backpressure. Back-to-back dequeues see the state updated by the previous one.
- The CL path (count increment → control law → drop_next) is single-cycle combinational.
- Reset (async, any time, including mid-episode): state NOT_DROPPING, all registers and outputs 0. The first dequeue after deassertion behaves as a cold start.
- i__target and i__interval changes take effect on the next dequeue. There is no retroactive recompute of drop_next.

## Configuration
- CODEL_DROP_STATS_EN defined: adds output o__drop_total (32 bits), incremented on every o__drop strobe. It saturates, resets to 0, and has no extra latency.
- Macro undefined: port and counter are absent; decision behaviour is identical.

## Structure
- CodelPkg: TimeCtr and Count typedefs, the FSM state enum, and a time_ge(a,b) signed-difference function. The bench model uses the same function.
- Sub-module: compute_control_law, instanced once. Its base input is muxed between drop_next (DROPPING) and i__now (entry), and its count input receives the post-update count.

## Test plan
- Sojourn 3, target 5, interval 100, backlog 4000, 10 dequeues → all forwarded, o__dropping=0, first_above stays 0.
- Sojourn 10 constant from now=1000, backlog 4000 → no drops before now=1100. First drop at the first dequeue with now≥1100, count=1, drop_next=CL(now,1).
- In DROPPING, dequeue at now<drop_next → forward. Dequeue at now=drop_next → drop, count=2, drop_next=CL(old drop_next,2).
- Sojourn falls to 2 mid-episode → next decision forwards, o__dropping=0. Re-entry within 16·interval with count=5, last_count=1 → count=4.
- i__now set near 0xFFFF_FFF0 with interval 100 → first_above wraps past 0, and the drop still occurs 100 ticks later. Also cover the now+interval=0 case, which must store 1.
- Assert rst_n mid-DROPPING with count=7 → outputs 0 immediately, without waiting for a clock edge. With CODEL_DROP_STATS_EN, o__drop_total also clears.
